// File: rtl/bit_stream_pkg.sv
// Shared definitions for the bit_stream_tx serial character transmitter.
package bit_stream_pkg;

  // Default character width.
  localparam int DEFAULT_DATA_W = 8;

  // Serializer state encoding; also visible on the dbg_state port.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    SHIFT = 2'd2
  } state_t;

endpackage

// File: rtl/bs_fifo.sv
// Small circular input buffer with a combinational head output.
// DEPTH must be a power of two (>= 2) so pointers wrap by overflow.
module bs_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_wr;
  logic             do_rd;

  // Guard both ports so a misbehaving caller cannot corrupt the count.
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy tracking; reset flushes the buffer.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bit_stream_tx.sv
// Serial character transmitter feeding the pattern-matcher cell chain.
// Characters arrive on a valid/ready port, are buffered, then shifted out
// one bit per enabled clock. A frame start inserts one clear cycle that
// pulses m_reset before the first bit of the new frame.
//
// Handshake: a character transfers on a clk edge where in_valid and
// in_ready are both 1; the sender must hold in_data/in_sof/in_valid
// stable until that edge. in_ready depends only on buffer occupancy
// (never on in_valid) and is 0 while reset_ is low.
module bit_stream_tx
  import bit_stream_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int FIFO_DEPTH = 2,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sof,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              bit_en,
  output logic              ip_c,
  output logic              bit_valid,
  output logic              bit_last,
  output logic              m_reset,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt;

  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W:0]   head;
  logic              head_sof;
  logic [DATA_W-1:0] head_data;
  logic              pop;
  logic              cur_bit;
  logic [DATA_W-1:0] shifted;
  logic              at_last;

  assign in_ready  = reset_ & ~fifo_full;
  assign head_sof  = head[DATA_W];
  assign head_data = head[DATA_W-1:0];
  assign at_last   = (cnt == CNT_LAST);
  assign busy      = ~fifo_empty | (state != IDLE);
  assign dbg_state = state;

  assign cur_bit = MSB_FIRST ? shreg[DATA_W-1] : shreg[0];
  assign shifted = MSB_FIRST ? {shreg[DATA_W-2:0], 1'b0}
                             : {1'b0, shreg[DATA_W-1:1]};

  bs_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_  (reset_),
    .wr_en   (in_valid & in_ready),
    .wr_data ({in_sof, in_data}),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Pop the head when idle, or on the final bit of a character so the
  // next one follows without a bubble.
  always_comb begin
    pop = 1'b0;
    if (bit_en && !fifo_empty) begin
      case (state)
        IDLE:    pop = 1'b1;
        SHIFT:   pop = at_last;
        default: pop = 1'b0;
      endcase
    end
  end

  // Serializer FSM with registered outputs; bit_en low freezes everything
  // except that bit_valid/bit_last drop (bit_last only qualifies a valid bit).
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      ip_c      <= 1'b0;
      bit_valid <= 1'b0;
      bit_last  <= 1'b0;
      m_reset   <= 1'b1;
    end else begin
      m_reset <= bit_en && (state == CLR);
      if (!bit_en) begin
        bit_valid <= 1'b0;
        bit_last  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            bit_valid <= 1'b0;
            bit_last  <= 1'b0;
            if (pop) begin
              shreg <= head_data;
              cnt   <= '0;
              state <= head_sof ? CLR : SHIFT;
            end
          end
          CLR: begin
            bit_valid <= 1'b0;
            bit_last  <= 1'b0;
            cnt       <= '0;
            state     <= SHIFT;
          end
          SHIFT: begin
            ip_c      <= cur_bit;
            bit_valid <= 1'b1;
            bit_last  <= at_last;
            if (at_last) begin
              cnt <= '0;
              if (pop) begin
                shreg <= head_data;
                state <= head_sof ? CLR : SHIFT;
              end else begin
                state <= IDLE;
              end
            end else begin
              shreg <= shifted;
              cnt   <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bit_stream_tx.sv
// Directed bench for bit_stream_tx: frame clear, back-to-back characters,
// full buffer backpressure, bit_en freeze, frame restart, and mid-character reset.
module tb_bit_stream_tx;

  localparam int DATA_W = 8;

  logic              clk;
  logic              reset_;
  logic [DATA_W-1:0] in_data;
  logic              in_sof;
  logic              in_valid;
  logic              in_ready;
  logic              bit_en;
  logic              ip_c;
  logic              bit_valid;
  logic              bit_last;
  logic              m_reset;
  logic              busy;
  logic [1:0]        dbg_state;

  // Scoreboard: each entry is {is_last_bit, bit_value}.
  logic [1:0] exp_q[$];
  int         bit_cyc[$];
  int         mres_cyc[$];
  int         nbits;
  int         nmres;
  int         cyc;
  int         last_acc;
  int         chk_cnt;
  int         pass_cnt;

  bit_stream_tx #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (2),
    .MSB_FIRST  (1'b1)
  ) dut (
    .clk       (clk),
    .reset_    (reset_),
    .in_data   (in_data),
    .in_sof    (in_sof),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bit_en    (bit_en),
    .ip_c      (ip_c),
    .bit_valid (bit_valid),
    .bit_last  (bit_last),
    .m_reset   (m_reset),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock and cycle counter.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Monitor: compare every valid bit with the scoreboard and log timing.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_) begin
        if (bit_valid) begin
          nbits++;
          bit_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            check("extra_bit", 32'd1, 32'd0);
          end else begin
            logic [1:0] e;
            e = exp_q.pop_front();
            check("ip_c", {31'd0, ip_c}, {31'd0, e[0]});
            check("bit_last", {31'd0, bit_last}, {31'd0, e[1]});
          end
        end
        if (m_reset) begin
          nmres++;
          mres_cyc.push_back(cyc);
          check("mres_bv_low", {31'd0, bit_valid}, 32'd0);
        end
      end
    end
  end

  task automatic start_test();
    nbits = 0;
    nmres = 0;
    bit_cyc.delete();
    mres_cyc.delete();
  endtask

  // Driver: offer one character, hold until accepted, push expected bits.
  task automatic send(input logic [DATA_W-1:0] d, input logic s);
    int g;
    g = 0;
    in_data  = d;
    in_sof   = s;
    in_valid = 1'b1;
    while (!in_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (g >= 300) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    last_acc = cyc;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      exp_q.push_back({(i == 0), d[i]});
    end
  endtask

  task automatic wait_bits(input int target);
    int g;
    g = 0;
    while (nbits < target && g < 400) begin
      @(posedge clk);
      g++;
    end
    check("bits_seen", nbits, target);
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n_at_reset;
    int g;
    chk_cnt  = 0;
    pass_cnt = 0;
    nbits    = 0;
    nmres    = 0;
    last_acc = 0;
    reset_   = 1'b0;
    in_data  = '0;
    in_sof   = 1'b0;
    in_valid = 1'b0;
    bit_en   = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ip_c", {31'd0, ip_c}, 32'd0);
    check("rst_bit_valid", {31'd0, bit_valid}, 32'd0);
    check("rst_bit_last", {31'd0, bit_last}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_m_reset", {31'd0, m_reset}, 32'd1);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    reset_ = 1'b1;
    @(negedge clk);
    check("rel_m_reset", {31'd0, m_reset}, 32'd0);
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // 1: single framed character A5 -> clear, then 10100101.
    start_test();
    send(8'hA5, 1'b1);
    wait_bits(8);
    check("t1_nmres", nmres, 1);
    check("t1_mres_lat", mres_cyc[0] - last_acc, 2);
    check("t1_bit_lat", bit_cyc[0] - last_acc, 3);
    check("t1_span", bit_cyc[7] - bit_cyc[0] + 1, 8);
    check("t1_busy", {31'd0, busy}, 32'd0);
    check("t1_state", {30'd0, dbg_state}, 32'd0);
    check("t1_q_empty", exp_q.size(), 0);

    // 2: 0F (sof) then F0 back-to-back -> 16 contiguous bits, one clear.
    start_test();
    send(8'h0F, 1'b1);
    send(8'hF0, 1'b0);
    wait_bits(16);
    check("t2_nmres", nmres, 1);
    check("t2_span", bit_cyc[15] - bit_cyc[0] + 1, 16);
    check("t2_q_empty", exp_q.size(), 0);

    // 3: fill the buffer while frozen; third write is held off.
    start_test();
    bit_en = 1'b0;
    send(8'h3C, 1'b1);
    send(8'h81, 1'b0);
    @(negedge clk);
    check("t3_full_ready", {31'd0, in_ready}, 32'd0);
    check("t3_busy", {31'd0, busy}, 32'd1);
    fork
      send(8'h7E, 1'b0);
    join_none
    repeat (3) @(negedge clk);
    check("t3_still_blocked", {31'd0, in_ready}, 32'd0);
    check("t3_idle_frozen", {30'd0, dbg_state}, 32'd0);
    @(posedge clk);
    #1;
    bit_en = 1'b1;
    wait_bits(24);
    check("t3_nmres", nmres, 1);
    check("t3_span", bit_cyc[23] - bit_cyc[0] + 1, 24);
    check("t3_q_empty", exp_q.size(), 0);

    // 4: freeze two cycles mid C3; sequence unchanged, two gaps.
    start_test();
    send(8'hC3, 1'b0);
    g = 0;
    while (nbits < 1 && g < 100) begin
      @(posedge clk);
      g++;
    end
    check("t4_started", nbits, 1);
    #1;
    bit_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t4_frz1_bv", {31'd0, bit_valid}, 32'd0);
    check("t4_frz1_ip_c", {31'd0, ip_c}, 32'd1);
    check("t4_frz1_state", {30'd0, dbg_state}, 32'd2);
    @(negedge clk);
    check("t4_frz2_bv", {31'd0, bit_valid}, 32'd0);
    check("t4_frz2_ip_c", {31'd0, ip_c}, 32'd1);
    bit_en = 1'b1;
    wait_bits(8);
    check("t4_span", bit_cyc[7] - bit_cyc[0] + 1, 10);
    check("t4_q_empty", exp_q.size(), 0);

    // 5: 01 then new frame 55 -> one clear bubble between them.
    start_test();
    send(8'h01, 1'b1);
    send(8'h55, 1'b1);
    wait_bits(16);
    check("t5_nmres", nmres, 2);
    check("t5_gap", bit_cyc[8] - bit_cyc[7], 2);
    check("t5_mres_pos", mres_cyc[1] - bit_cyc[7], 1);
    check("t5_q_empty", exp_q.size(), 0);

    // 6: reset during FF with a second character queued.
    start_test();
    send(8'hFF, 1'b0);
    send(8'h12, 1'b0);
    g = 0;
    while (nbits < 3 && g < 100) begin
      @(posedge clk);
      g++;
    end
    check("t6_started", nbits, 3);
    #1;
    reset_ = 1'b0;
    n_at_reset = nbits;
    exp_q.delete();
    #1;
    check("t6_ip_c", {31'd0, ip_c}, 32'd0);
    check("t6_bv", {31'd0, bit_valid}, 32'd0);
    check("t6_m_reset", {31'd0, m_reset}, 32'd1);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) @(negedge clk);
    reset_ = 1'b1;
    repeat (20) @(negedge clk);
    check("t6_no_output", nbits, n_at_reset);
    check("t6_m_reset_off", {31'd0, m_reset}, 32'd0);
    check("t6_idle_busy", {31'd0, busy}, 32'd0);

    // Fresh unframed character after reset: two-clock latency.
    start_test();
    send(8'h96, 1'b0);
    wait_bits(8);
    check("t7_bit_lat", bit_cyc[0] - last_acc, 2);
    check("t7_nmres", nmres, 0);
    check("t7_q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
